// File: rtl/mbe_rad4_pkg.sv
// Shared widths and FSM state type for the radix-4 modified-Booth sequential multiplier.
package mbe_rad4_pkg;
  localparam int A_W      = 11;
  localparam int B_W      = 11;
  localparam int P_W      = 22;
  localparam int N_DIGITS = 6;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mbe_rad4_seq_mult_if.sv
// Operand/product handshake bundle between a producer/consumer and the multiplier.
interface mbe_rad4_seq_mult_if;
  import mbe_rad4_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic signed [A_W-1:0] a;
  logic signed [B_W-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [P_W-1:0]        p;
  logic                  busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/booth_encoder_rad4.sv
// Radix-4 Booth digit encoder: selects 0, a or 2a (sign-extended) and flags negation.
module booth_encoder_rad4
  import mbe_rad4_pkg::*;
(
  input  logic           b_next,
  input  logic           b_n,
  input  logic           b_prev,
  input  logic [A_W-1:0] A,
  output logic           neg,
  output logic [A_W:0]   A_out
);
  logic one_sel;
  logic two_sel;

  assign one_sel = b_n ^ b_prev;
  assign two_sel = (b_next & ~b_n & ~b_prev) | (~b_next & b_n & b_prev);
  // Triplet 111 encodes zero, so it must not request negation.
  assign neg     = b_next & ~(b_n & b_prev);

  always_comb begin
    A_out = '0;
    if (one_sel) begin
      A_out = {A[A_W-1], A};
    end else if (two_sel) begin
      A_out = {A, 1'b0};
    end
  end
endmodule

// File: rtl/mbe_rad4_seq_mult.sv
// Sequential signed 11x11 multiplier retiring one radix-4 Booth digit per clock.
module mbe_rad4_seq_mult
  import mbe_rad4_pkg::*;
(
  input logic                clk,
  input logic                rst,
  mbe_rad4_seq_mult_if.slave bus
);
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [A_W-1:0]        a_q, a_d;
  logic [B_W+1:0]        b_q, b_d;
  logic [P_W-1:0]        acc_q, acc_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic [B_W+1:0]        b_shift;
  logic [2:0]            trip;
  logic                  neg;
  logic [A_W:0]          a_out;
  logic [P_W-1:0]        pp_ext;
  logic [P_W-1:0]        pp;
  logic                  accept;
  logic                  out_hs;

  assign b_shift = b_q >> {cnt_q, 1'b0};
  assign trip    = b_shift[2:0];

  booth_encoder_rad4 u_enc (
    .b_next (trip[2]),
    .b_n    (trip[1]),
    .b_prev (trip[0]),
    .A      (a_q),
    .neg    (neg),
    .A_out  (a_out)
  );

  // Negate after widening: -(2 * -1024) does not fit the 12-bit encoder output.
  assign pp_ext = {{(P_W-A_W-1){a_out[A_W]}}, a_out};
  assign pp     = neg ? (~pp_ext + 1'b1) : pp_ext;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign out_hs = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = {bus.b[B_W-1], bus.b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = acc_q + (pp << {cnt_q, 1'b0});
        if (cnt_q == CNT_W'(N_DIGITS - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.p         = acc_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mbe_rad4_seq_mult.sv
// Directed and back-to-back checks of the radix-4 Booth sequential multiplier.
module tb_mbe_rad4_seq_mult;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mbe_rad4_seq_mult_if bus ();

  mbe_rad4_seq_mult dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Presents one operand pair, then waits (bounded) for out_valid; lat counts the accepting edge as 1.
  task automatic run_one(input logic signed [10:0] av, input logic signed [10:0] bv,
                         output logic [21:0] pv, output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    pv = bus.p;
  endtask

  task automatic handshake;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b1; bus.a = 11'sd5; bus.b = 11'sd5; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.p !== 22'h0) begin failures++; $display("FAIL reset_p got %h want 000000", bus.p); end
    rst = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    logic [21:0] pv;
    int lat;
    run_one(11'sd1000, -11'sd3, pv, lat);
    checks++; if (pv !== 22'h3FF448) begin failures++; $display("FAIL basic_p got %h want 3ff448", pv); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL basic_latency got %0d want 7", lat); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got %b want 1", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_done got %b want 0", bus.in_ready); end
    handshake();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready_after got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_out_valid_after got %b want 0", bus.out_valid); end
    $display("test_basic a=1000 b=-3 p=%h lat=%0d", pv, lat);
  endtask

  task automatic test_corners;
    int          ta[6] = '{-1024, 1023, 0, 517, 3, -5};
    int          tb[6] = '{-1024, -1024, 517, 0, 718, 718};
    logic [21:0] te[6] = '{22'h100000, 22'h300400, 22'h000000, 22'h000000, 22'h00086A, 22'h3FF1FA};
    logic [21:0] pv;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_one(11'(ta[i]), 11'(tb[i]), pv, lat);
      checks++; if (pv !== te[i]) begin failures++; $display("FAIL corner_p[%0d] got %h want %h", i, pv, te[i]); end
      checks++; if (lat !== 7) begin failures++; $display("FAIL corner_latency[%0d] got %0d want 7", i, lat); end
      $display("test_corners a=%0d b=%0d p=%h", ta[i], tb[i], pv);
      handshake();
    end
  endtask

  task automatic test_backpressure;
    logic [21:0] pv;
    int lat;
    run_one(11'sd12, 11'sd34, pv, lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.p !== 22'h000198) begin failures++; $display("FAIL bp_p[%0d] got %h want 000198", i, bus.p); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
      @(posedge clk); #1;
    end
    handshake();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got %b want 0", bus.out_valid); end
    $display("test_backpressure a=12 b=34 p=%h", pv);
  endtask

  task automatic test_ignore;
    int lat = 1;
    bus.a = -11'sd7; bus.b = 11'sd100; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 11'sd333; bus.b = -11'sd111;
    while (!bus.out_valid && lat < 20) begin
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ignore_in_ready got %b want 0", bus.in_ready); end
      @(posedge clk); #1; lat++;
    end
    checks++; if (bus.p !== 22'h3FFD44) begin failures++; $display("FAIL ignore_p got %h want 3ffd44", bus.p); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL ignore_latency got %0d want 7", lat); end
    bus.in_valid = 1'b0;
    $display("test_ignore a=-7 b=100 p=%h", bus.p);
    handshake();
  endtask

  task automatic test_reset_abort;
    logic [21:0] pv;
    int lat;
    bus.a = 11'sd1000; bus.b = -11'sd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_busy_run got %b want 1", bus.busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.p !== 22'h0) begin failures++; $display("FAIL abort_p got %h want 000000", bus.p); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    run_one(11'sd7, 11'sd9, pv, lat);
    checks++; if (pv !== 22'h00003F) begin failures++; $display("FAIL abort_next_p got %h want 00003f", pv); end
    checks++; if (lat !== 7) begin failures++; $display("FAIL abort_next_latency got %0d want 7", lat); end
    $display("test_reset_abort next a=7 b=9 p=%h", pv);
    handshake();
  endtask

  task automatic test_back_to_back;
    logic [21:0] exp_q[$];
    logic [21:0] e;
    int n_acc = 0;
    int n_out = 0;
    int cyc = 0;
    int last_out = -1;
    int bad = 0;
    logic do_acc, do_out;
    bus.a = 11'($urandom); bus.b = 11'($urandom);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    while (n_out < 1000 && cyc < 9000) begin
      do_acc = bus.in_valid && bus.in_ready;
      do_out = bus.out_valid;
      if (do_out) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h0;
        checks++;
        if (bus.p !== e) begin failures++; bad++; $display("FAIL b2b_p[%0d] got %h want %h", n_out, bus.p, e); end
        if (last_out >= 0) begin
          checks++;
          if (cyc - last_out !== 8) begin failures++; $display("FAIL b2b_period[%0d] got %0d want 8", n_out, cyc - last_out); end
        end
        last_out = cyc;
        n_out++;
      end
      if (do_acc) exp_q.push_back(22'(int'(bus.a) * int'(bus.b)));
      @(posedge clk); #1;
      cyc++;
      if (do_acc) begin
        n_acc++;
        if (n_acc == 1000) bus.in_valid = 1'b0;
        else begin bus.a = 11'($urandom); bus.b = 11'($urandom); end
      end
    end
    checks++;
    if (n_out !== 1000) begin failures++; $display("FAIL b2b_count got %0d want 1000", n_out); end
    bus.out_ready = 1'b0;
    $display("test_back_to_back products=%0d cycles=%0d p_errors=%0d", n_out, cyc, bad);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
